bytebeat_voice_scheduler: RTL

Sample-rate controller for the bank of bytebeat generator voices. Replaces the free-running clock divider: it generates the audio sample tick, polls each voice's output valid/ready channel in a fixed order, and captures each voice's sample into a hold register. It then produces one selected or averaged 8-bit sample per tick for the PWM audio stage, with a one-cycle strobe, and flags missed voices and overruns.

---
 rtl/bytebeat_pkg.sv | 9 +
 rtl/bytebeat_tick_gen.sv | 18 +
 rtl/bytebeat_voice_scheduler.sv | 97 +++++++++
 3 files changed

// File: rtl/bytebeat_pkg.sv
// bytebeat_pkg: shared types and constants for the bytebeat audio blocks
package bytebeat_pkg;
   typedef enum logic [1:0] {IDLE, POLL, MIX} sched_state_t;
   localparam int SAMPLE_W = 8;
   localparam logic [SAMPLE_W-1:0] SAMPLE_MID = 8'h80;
   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction
endpackage

// File: rtl/bytebeat_tick_gen.sv
// bytebeat_tick_gen: free-running prescaler, tick high on the last count of each period
module bytebeat_tick_gen
   import bytebeat_pkg::*;
#(
   parameter int TICK_DIV = 512
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);
   localparam int CW = idx_w(TICK_DIV);
   logic [CW-1:0] count;
   assign tick = count == CW'(TICK_DIV - 1);
   // count 0..TICK_DIV-1 and wrap
   always_ff @(posedge clk) begin
      count <= (reset || tick) ? '0 : count + 1'b1;
   end
endmodule

// File: rtl/bytebeat_voice_scheduler.sv
// bytebeat_voice_scheduler: ticks, polls each voice in order, holds samples and emits one mixed sample per tick
module bytebeat_voice_scheduler
   import bytebeat_pkg::*;
#(
   parameter int NUM_VOICES   = 8,
   parameter int TICK_DIV     = 512,
   parameter int POLL_TIMEOUT = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_VOICES-1:0]          voice_en,
   input  logic                           mix_mode,
   input  logic [2:0]                     sel,
   input  logic [SAMPLE_W*NUM_VOICES-1:0] pcm_in,
   input  logic [NUM_VOICES-1:0]          pcm_vld,
   output logic [NUM_VOICES-1:0]          pcm_rdy,
   output logic [SAMPLE_W-1:0]            sample_out,
   output logic                           sample_stb,
   output logic [NUM_VOICES-1:0]          miss,
   output logic                           overrun,
   input  logic                           clr_flags
);
   localparam int IW = idx_w(NUM_VOICES);
   localparam int WW = idx_w(POLL_TIMEOUT + 1);
   localparam int SW = SAMPLE_W + IW;
   sched_state_t state, state_nx;
   logic tick, en_cur, vld_cur, hs, tmo, adv, last;
   logic [IW-1:0] idx;
   logic [WW-1:0] wait_cnt;
   logic [SAMPLE_W-1:0] hold [NUM_VOICES];
   logic [SAMPLE_W-1:0] sel_ext [8];
   logic [SAMPLE_W-1:0] mix_val;
   logic [SW-1:0] sum;
   logic [NUM_VOICES-1:0] tmo_vec;

   bytebeat_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   // poll handshake, timeout and next-state decode for the current voice slot
   always_comb begin
      en_cur   = voice_en[idx];
      vld_cur  = pcm_vld[idx];
      hs       = (state == POLL) && en_cur && vld_cur;
      tmo      = (state == POLL) && en_cur && !vld_cur && (wait_cnt == WW'(POLL_TIMEOUT - 1));
      adv      = (state == POLL) && (!en_cur || vld_cur || tmo);
      last     = idx == IW'(NUM_VOICES - 1);
      tmo_vec  = NUM_VOICES'(tmo) << idx;
      pcm_rdy  = '0;
      state_nx = state;
      if (state == POLL && en_cur) pcm_rdy[idx] = 1'b1;
      if (state == IDLE && tick) state_nx = POLL;
      if (adv && last) state_nx = MIX;
      if (state == MIX) state_nx = IDLE;
   end

   // mix value: average over all holds, or the selected hold with unused selects reading mid-scale
   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_VOICES; i++) sum = sum + SW'(hold[i]);
      for (int i = 0; i < 8; i++) sel_ext[i] = SAMPLE_MID;
      for (int i = 0; i < NUM_VOICES; i++) sel_ext[i] = hold[i];
      mix_val = mix_mode ? sum[IW +: SAMPLE_W] : sel_ext[sel];
   end

   // scheduler state, sample holds, output register and sticky flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         wait_cnt   <= '0;
         sample_out <= SAMPLE_MID;
         sample_stb <= 1'b0;
         miss       <= '0;
         overrun    <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) hold[i] <= SAMPLE_MID;
      end else begin
         state      <= state_nx;
         sample_stb <= state == MIX;
         if (state == MIX) sample_out <= mix_val;
         if (state == IDLE && tick) begin
            idx      <= '0;
            wait_cnt <= '0;
         end else if (adv) begin
            idx      <= idx + 1'b1;
            wait_cnt <= '0;
         end else if (state == POLL) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (hs) hold[idx] <= pcm_in[idx*SAMPLE_W +: SAMPLE_W];
         miss    <= (clr_flags ? '0 : miss) | tmo_vec;
         overrun <= (overrun && !clr_flags) || (tick && state != IDLE);
      end
   end
endmodule
